data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 30 +++
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder_dmem_array.sv | 42 ++++
 rtl/data_mem_responder.sv | 119 +++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
//   state_t          : FSM state encoding (IDLE / WAIT / RESP)
//   req_t            : captured request payload
//   DEFAULT_DEPTH    : default number of 32-bit words
//   DEFAULT_LATENCY  : default accept-to-response latency
//   ERR_RDATA        : read data returned for stores and errored requests
package data_mem_responder_pkg;

    localparam int unsigned DEFAULT_DEPTH   = 32;
    localparam int unsigned DEFAULT_LATENCY = 2;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BE_W            = DATA_W / 8;
    localparam int unsigned CNT_W           = 4;

    localparam logic [DATA_W-1:0] ERR_RDATA = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a core (master) and the memory responder (slave).
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_be : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                   : response channel
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// DEPTH x 32-bit storage with a byte-enable write port, one combinational
// read port sharing the same word index, and asynchronous clear.
//   clk, reset : clock, async active-low clear of every word
//   we, be     : write strobe and byte-lane enables
//   idx        : word index for both read and write
//   wdata      : write data
//   rdata_c    : combinational read of word idx
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [BE_W-1:0]          be,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; whole array cleared while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Guard against indices past the end when DEPTH is not a power of two.
    assign rdata_c = (32'(idx) < DEPTH) ? mem[idx] : '0;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed accept-to-response
// latency. Accepts one request in IDLE, waits LATENCY cycles, commits the
// access on the edge entering RESP and holds the response until taken.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : slave side of the request/response bus
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = DEFAULT_LATENCY,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    req_t              req_q;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    req_t              req_in;
    req_t              acc;
    logic              accept;
    logic              enter_resp;
    logic              acc_err;
    logic              mem_we;
    logic [AW-1:0]     mem_idx;
    logic [DATA_W-1:0] mem_rdata_c;
    logic [CNT_W-1:0]  cnt_dec;

    // Access decode. With LATENCY=1 the access commits on the accept edge,
    // so it must use the live bus fields rather than the captured copy.
    always_comb begin
        req_in     = '{write: bus.req_write, addr: bus.req_addr,
                       wdata: bus.req_wdata, be: bus.req_be};
        accept     = bus.req_valid && req_ready && (state == IDLE);
        cnt_dec    = cnt - CNT_W'(1);
        enter_resp = (accept && (LATENCY == 1)) ||
                     ((state == WAIT) && (cnt_dec == '0));
        acc        = (state == IDLE) ? req_in : req_q;
        acc_err    = (acc.addr[1:0] != 2'b00) || (acc.addr >= 32'(4 * DEPTH));
        mem_we     = enter_resp && acc.write && !acc_err;
        mem_idx    = acc.addr[AW+1:2];
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_dmem_array (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we),
        .idx     (mem_idx),
        .be      (acc.be),
        .wdata   (acc.wdata),
        .rdata_c (mem_rdata_c)
    );

    // FSM, latency counter and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (enter_resp) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (acc.write || acc_err) ? ERR_RDATA : mem_rdata_c;
            end
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_q     <= req_in;
                        req_ready <= 1'b0;
                        if (LATENCY != 1) begin
                            state <= WAIT;
                            cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                // Leaves on the edge where the counter reaches 0.
                WAIT: begin
                    cnt <= cnt_dec;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;

endmodule
